// File: rtl/onehot_decoder_scan.sv
// Registered N-to-2^N one-hot decoder with enable, polarity select and an auto-scan
// mode that walks every output, stepping once per SCAN_DIV enabled cycles.
module onehot_decoder_scan #(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    ld,
  output logic [(1<<SEL_W)-1:0]   dout,
  output logic [SEL_W-1:0]        idx,
  output logic                    valid,
  output logic                    wrap
);
  localparam int unsigned OUT_W = 1 << SEL_W;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [OUT_W-1:0] INACT    = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);

  logic [OUT_W-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             mode_q, mode_d;

  always_comb begin
    dout_d  = INACT;
    idx_d   = idx_q;
    div_d   = div_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    mode_d  = mode_q;
    // en low only blanks the outputs; idx, divider and mode_q hold so a scan resumes
    if (en) begin
      valid_d = 1'b1;
      mode_d  = mode;
      if (!mode) begin
        idx_d = sel;
        div_d = '0;
      end else if (!mode_q || ld) begin
        idx_d = sel;
        div_d = '0;
      end else if (div_q == DIV_LAST) begin
        div_d  = '0;
        idx_d  = idx_q + 1'b1;
        wrap_d = (idx_q == '1);
      end else begin
        div_d = div_q + 1'b1;
      end
      dout_d = (ONE << idx_d) ^ INACT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= INACT;
      idx_q   <= '0;
      div_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode_d;
    end
  end

  assign dout  = dout_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;
endmodule
